// File: rtl/add_test_3.sv
// Registered WIDTH-bit unsigned adder built from a ripple chain of LANE-bit digit adders.
// Optional registered carry_out of the top lane when ADD_CARRY_OUT_EN is defined.
module add_test_3 #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANE  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
`ifdef ADD_CARRY_OUT_EN
    output logic             carry_out,
`endif
    output logic [WIDTH-1:0] r_result_bus
);

    localparam int unsigned NL = WIDTH / LANE;

    logic [NL:0]      lane_c;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;

    assign lane_c[0] = 1'b0;

    // Each lane adds its digits plus the carry rippled in from the lane below.
    for (genvar k = 0; k < NL; k++) begin : g_lane
        logic [LANE:0] lane_sum;

        assign lane_sum = {1'b0, r1[k*LANE +: LANE]}
                        + {1'b0, r2[k*LANE +: LANE]}
                        + {{LANE{1'b0}}, lane_c[k]};
        assign sum_d[k*LANE +: LANE] = lane_sum[LANE-1:0];
        assign lane_c[k+1]           = lane_sum[LANE];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign r_result_bus = sum_q;

`ifdef ADD_CARRY_OUT_EN
    logic carry_d;
    logic carry_q;

    assign carry_d = lane_c[NL];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
`else
    // Top-lane carry is intentionally dropped in this build.
    logic unused_carry;
    assign unused_carry = lane_c[NL];
`endif

endmodule

// File: tb/tb_add_test_3.sv
// Directed and randomized bench for add_test_3; expected sums come from plain integer arithmetic.
module tb_add_test_3;

    logic        clk;
    logic        rst_n;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r_result_bus;
`ifdef ADD_CARRY_OUT_EN
    logic        carry_out;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    add_test_3 #(
        .WIDTH(16),
        .LANE (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .r1          (r1),
        .r2          (r2),
`ifdef ADD_CARRY_OUT_EN
        .carry_out   (carry_out),
`endif
        .r_result_bus(r_result_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sum(input int unsigned a, input int unsigned b);
        return 16'((a + b) % 65536);
    endfunction

    function automatic logic ref_carry(input int unsigned a, input int unsigned b);
        return (a + b) >= 65536;
    endfunction

    task automatic check_sum(input string tag, input logic [15:0] exp);
        vectors++;
        assert (r_result_bus === exp)
        else begin
            miscompares++;
            $error("FAIL %s: r_result_bus=%0d expected=%0d", tag, r_result_bus, exp);
        end
    endtask

    task automatic check_carry(input string tag, input logic exp);
`ifdef ADD_CARRY_OUT_EN
        vectors++;
        assert (carry_out === exp)
        else begin
            miscompares++;
            $error("FAIL %s: carry_out=%0b expected=%0b", tag, carry_out, exp);
        end
`else
        if (exp === 1'bx) $error("FAIL %s: bad expected carry", tag);
`endif
    endtask

    // Apply operands, clock once, sample 1 time unit after the edge.
    task automatic add_step(input string tag, input int unsigned a, input int unsigned b);
        r1 = 16'(a);
        r2 = 16'(b);
        @(posedge clk);
        #1;
        check_sum(tag, ref_sum(a, b));
        check_carry(tag, ref_carry(a, b));
    endtask

    initial begin
        int unsigned a;
        int unsigned b;

        vectors     = 0;
        miscompares = 0;

        rst_n = 1'b0;
        r1    = 16'd1234;
        r2    = 16'd4321;
        @(posedge clk);
        #1;
        check_sum("reset_edge1", 16'd0);
        check_carry("reset_edge1", 1'b0);
        @(posedge clk);
        #1;
        check_sum("reset_edge2", 16'd0);
        check_carry("reset_edge2", 1'b0);

        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_sum("reset_release", 16'd5555);

        add_step("smoke", 2, 4);
        add_step("lane_carry_8888", 34952, 34952);
        add_step("ripple_0fff", 16'h0FFF, 16'h0001);
        add_step("wrap_full", 65535, 1);
        add_step("wrap_max", 65535, 65535);
        add_step("zero", 0, 0);

        // Output must hold while operands change between edges.
        add_step("hold_first", 100, 200);
        r1 = 16'd7;
        r2 = 16'd8;
        #3;
        check_sum("hold_between", 16'd300);
        @(posedge clk);
        #1;
        check_sum("hold_next", 16'd15);

        // Reset overrides a pending add.
        r1    = 16'd1000;
        r2    = 16'd2000;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_sum("reset_override", 16'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            a = $urandom_range(9999, 0);
            b = $urandom_range(19999, 0);
            add_step("rand_small", a, b);
        end

        for (int i = 0; i < 20; i++) begin
            a = $urandom_range(65535, 0);
            b = $urandom_range(65535, 0);
            add_step("rand_full", a, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/add_test_3.md
Name: add_test_3

Overview:
- Registered 16-bit unsigned adder with a bus converter front/back end.
- Operand buses are split into 4-bit digit lanes and summed by a ripple chain of nibble adders. The lanes are merged back to a 16-bit bus and registered on the rising clock edge.
- Used as the arithmetic leaf of the 16-bit add test designs. It drives a result bus sampled one clock after the operands are applied.

Parameters:
- WIDTH, 16, operand/result bus width; must be a multiple of LANE.
- LANE, 4, digit-lane width used by the converter; lane count NL = WIDTH/LANE (4 at defaults).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- r1  input  WIDTH  operand A, unsigned.
- r2  input  WIDTH  operand B, unsigned.
- r_result_bus  output  WIDTH  registered sum (A+B) mod 2^WIDTH.
- carry_out  output  1  registered carry out of the MSB lane; present only with ADD_CARRY_OUT_EN.

Behaviour:
- Reset: on a rising edge with rst_n=0, r_result_bus <= 0 (and carry_out <= 0). Reset overrides any add in the same cycle. After rst_n returns to 1, the next edge loads a normal sum.
- Converter in:
  - r1 and r2 are sliced into NL lanes; lane k = bits [k*LANE+LANE-1 : k*LANE].
  - The split is purely combinational; inputs are not registered separately.
- Lane adders:
  - Lane k computes {c[k+1], s[k]} = a[k] + b[k] + c[k], with c[0] = 0.
  - This forms a pure combinational ripple chain across lanes, with no pipelining between lanes.
- Converter out: s[NL-1..0] are concatenated back, MSB lane first, into a WIDTH-bit sum.
- Register: on each rising edge with rst_n=1, r_result_bus <= merged sum. No enable.
- Latency: exactly one rising edge from stable operands to a valid r_result_bus. The output is held stable between edges regardless of input changes.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH. Carry out of the top lane (c[NL]) is discarded from r_result_bus.
  - Example: 34952+34952 = 69904 -> 4368 (0x8888+0x8888 = 0x1110).
- Boundaries:
  - 0+0 = 0.
  - 65535+1 = 0 (full wrap).
  - 65535+65535 = 65534.
  - A carry propagates through all lanes when needed, e.g. 0x0FFF+0x0001 = 0x1000.
- Inputs changing between edges have no effect until the next edge. X/Z on inputs is out of scope.
- Output is never combinationally dependent on r1/r2.

Optional Feature:
- Macro ADD_CARRY_OUT_EN.
- Defined:
  - Adds the carry_out port.
  - carry_out is registered on the same edge as r_result_bus, equal to c[NL].
  - Reset value 0.
- Undefined:
  - The port is absent and c[NL] is left unused.
  - r_result_bus behaviour is identical in both builds.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with r1=1234, r2=4321 -> r_result_bus=0 (carry_out=0). Release rst_n; next edge -> 5555.
- Smoke: r1=2, r2=4, one rising edge -> r_result_bus=6.
- Multi-lane carry: r1=34952, r2=34952, one edge -> 4368 (carry_out=1 when enabled). Also r1=0x0FFF, r2=0x0001 -> 0x1000.
- Wrap extremes:
  - 65535+1 -> 0 (carry_out=1).
  - 65535+65535 -> 65534.
  - 0+0 -> 0.
- Hold/latency: change r1/r2 between edges -> r_result_bus unchanged until the next rising edge, then it equals the new sum.
- Random: 10 vectors, r1 in [0,9999], r2 in [0,19999], one edge each -> r_result_bus = r1+r2 (never exceeds 29998, so no wrap).
